// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the IF/MEM bus arbiter: FSM state codes, byte-select default and bus widths.
package bus_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_MEM_BUS = 2'd1;
  localparam logic [1:0] ARB_IF_BUS  = 2'd2;

  localparam logic [3:0] BUS_SEL_ALL = 4'b1111;

endpackage

// File: rtl/arb_hold_buf.sv
// Completion buffer for one pipeline port: keeps returned bus data until the owning stage advances.
module arb_hold_buf
  import bus_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              load_we_i,
  input  logic              consume_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_we_i,
  output logic              match_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;

  // A fresh completion wins over consumption of the previous one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (consume_i) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q <= load_data_i;
      addr_q <= load_addr_i;
      we_q   <= load_we_i;
    end
  end

  assign match_o = valid_q & (addr_q == req_addr_i) & (we_q == req_we_i);
  assign data_o  = (valid_q && !we_q) ? data_q : '0;

endmodule

// File: rtl/bus_arbiter.sv
// Shares one Wishbone-style bus between instruction fetch and load/store, MEM first, non-preemptive,
// with per-port hold buffers and a timeout abort so the pipeline can never hang on a dead slave.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_stallreq_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_stallreq_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              if_match, mem_match, if_pend, mem_pend;
  logic              in_bus, timeout, finish, if_load, mem_load;
  logic [DATA_W-1:0] fill_data;
  logic              unused_stall;

  assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  assign if_pend  = if_ce_i & ~if_match;
  assign mem_pend = mem_ce_i & ~mem_match;

  assign in_bus    = (state_q != ARB_IDLE);
  assign timeout   = in_bus & ~bus_ack_i & (cnt_q == TO_LAST);
  assign finish    = in_bus & (bus_ack_i | timeout);
  assign if_load   = finish & (state_q == ARB_IF_BUS);
  assign mem_load  = finish & (state_q == ARB_MEM_BUS);
  assign fill_data = bus_ack_i ? bus_data_i : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    if (!in_bus) begin
      if (mem_pend) begin
        state_d = ARB_MEM_BUS;
        we_d    = mem_we_i;
        sel_d   = mem_sel_i;
        addr_d  = mem_addr_i;
        wdata_d = mem_data_i;
      end else if (if_pend) begin
        state_d = ARB_IF_BUS;
        we_d    = 1'b0;
        sel_d   = BUS_SEL_ALL;
        addr_d  = if_addr_i;
        wdata_d = '0;
      end
    end else if (finish) begin
      // Always return through IDLE: one dead cycle between transactions.
      state_d = ARB_IDLE;
      cnt_d   = '0;
      err_d   = timeout;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  arb_hold_buf u_if_buf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (if_load),
    .load_data_i (fill_data),
    .load_addr_i (addr_q),
    .load_we_i   (1'b0),
    .consume_i   (~stall_i[1]),
    .req_addr_i  (if_addr_i),
    .req_we_i    (1'b0),
    .match_o     (if_match),
    .data_o      (if_data_o)
  );

  arb_hold_buf u_mem_buf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (mem_load),
    .load_data_i (fill_data),
    .load_addr_i (addr_q),
    .load_we_i   (we_q),
    .consume_i   (~stall_i[4]),
    .req_addr_i  (mem_addr_i),
    .req_we_i    (mem_we_i),
    .match_o     (mem_match),
    .data_o      (mem_data_o)
  );

  assign if_stallreq_o  = if_pend;
  assign mem_stallreq_o = mem_pend;
  assign bus_cyc_o      = in_bus;
  assign bus_stb_o      = in_bus;
  assign bus_we_o       = we_q;
  assign bus_sel_o      = sel_q;
  assign bus_addr_o     = addr_q;
  assign bus_data_o     = wdata_q;
  assign bus_err_o      = err_q;

endmodule
